// File: rtl/buffer_pkg.sv
// Shared types and defaults for the activation-buffer stream sequencer.
// ADDR_RAM and N_BUF_RAM are the header macros supplying the address width
// and bank count defaults; they fall back to 10 and 8 when not defined.
`ifndef ADDR_RAM
`define ADDR_RAM 10
`endif
`ifndef N_BUF_RAM
`define N_BUF_RAM 8
`endif

package buffer_pkg;

  localparam int unsigned ADDR_W_DEF = `ADDR_RAM;
  localparam int unsigned N_BUF_DEF  = `N_BUF_RAM;
  localparam int unsigned WR_LAT_DEF = 3;

  // Sequencer FSM states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_t;

  // Flattened per-bank address vector; bank i sits at [i*ADDR_W +: ADDR_W].
  typedef logic [N_BUF_DEF*ADDR_W_DEF-1:0] bank_addr_vec_t;

endpackage

// File: rtl/buffer_stream_sequencer_if.sv
// Layer-controller / buffer-bank bus of the stream sequencer.
//
// Handshake: start is a request (valid) that is accepted only on a cycle
// where busy is low (ready = !busy). A start seen while busy is dropped, not
// queued. The configuration fields are captured in the accepting cycle only.
// stall is back-pressure: while high, nothing advances and all enables are 0.
interface buffer_stream_sequencer_if
#(
  parameter int unsigned N_BUF  = buffer_pkg::N_BUF_DEF,
  parameter int unsigned ADDR_W = buffer_pkg::ADDR_W_DEF
);
  import buffer_pkg::*;

  logic                      start;
  logic [ADDR_W-1:0]         rd_base;
  logic [ADDR_W-1:0]         wr_base;
  logic [ADDR_W-1:0]         stride;
  logic [ADDR_W:0]           len;
  logic [N_BUF-1:0]          bank_mask;
  logic                      stagger_en;
  logic                      stall;
  logic                      mode;
  logic [N_BUF-1:0]          m1_r_en;
  logic [N_BUF-1:0]          m1_w_en;
  logic [N_BUF*ADDR_W-1:0]   m1_r_addr;
  logic [N_BUF*ADDR_W-1:0]   m1_w_addr;
  logic                      busy;
  logic                      done;

  // Controller side.
  modport master (
    output start, rd_base, wr_base, stride, len, bank_mask, stagger_en, stall,
    input  mode, m1_r_en, m1_w_en, m1_r_addr, m1_w_addr, busy, done
  );

  // Sequencer side.
  modport slave (
    input  start, rd_base, wr_base, stride, len, bank_mask, stagger_en, stall,
    output mode, m1_r_en, m1_w_en, m1_r_addr, m1_w_addr, busy, done
  );

endinterface

// File: rtl/seq_delay_line.sv
// WIDTH x DEPTH shift register with hold and synchronous clear (rst_n).
// Data presented in cycle C appears on dout_o in cycle C+DEPTH, counting
// only cycles where hold_i is low.
module seq_delay_line
#(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 1
)
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             hold_i,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] dout_o
);

  logic [WIDTH-1:0] sr_q [DEPTH];

  // Shift one stage per un-held cycle; clear everything on reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) sr_q[i] <= '0;
    end else if (!hold_i) begin
      sr_q[0] <= din_i;
      for (int i = 1; i < DEPTH; i++) sr_q[i] <= sr_q[i-1];
    end
  end

  assign dout_o = sr_q[DEPTH-1];

endmodule

// File: rtl/buffer_stream_sequencer.sv
// Mode-1 read/write address and enable generator for the N_BUF-bank
// activation buffer. Bank 0 is fed by an address accumulator; other banks
// either copy bank 0 or follow it through a one-cycle-per-bank stagger chain.
// Each bank's write-back is its read enable delayed WR_LAT cycles.
// Optional feature macro: BUF_SEQ_PINGPONG_EN (swap buffer halves each pass).
module buffer_stream_sequencer
  import buffer_pkg::*;
#(
  parameter int unsigned N_BUF  = N_BUF_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned WR_LAT = WR_LAT_DEF
)
(
  input  logic                      clk,
  input  logic                      rst_n,
  buffer_stream_sequencer_if.slave  bus,
  output seq_state_t                state_o
);

  localparam int unsigned DW = (WR_LAT > 1) ? $clog2(WR_LAT) : 1;

  // One streamed element: enable plus its read and write addresses.
  typedef struct packed {
    logic              en;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] w_addr;
  } elem_t;

  seq_state_t        state_q, state_d;
  logic [ADDR_W:0]   k_q, k_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic [ADDR_W-1:0] stride_q, stride_d;
  logic [ADDR_W-1:0] rd_acc_q, rd_acc_d;
  logic [ADDR_W-1:0] wr_acc_q, wr_acc_d;
  logic [N_BUF-1:0]  mask_q, mask_d;
  logic              stag_q, stag_d;
  logic [DW-1:0]     drain_q, drain_d;
  logic [ADDR_W-1:0] msb_flip;

`ifdef BUF_SEQ_PINGPONG_EN
  logic pp_q, pp_d;
  // Half-select flips on each completed pass; reset starts at the low half.
  always_ff @(posedge clk) begin
    if (!rst_n) pp_q <= 1'b0;
    else        pp_q <= pp_d;
  end
  assign msb_flip = {pp_q, {(ADDR_W-1){1'b0}}};
`else
  assign msb_flip = '0;
`endif

  logic             b0_en;
  elem_t            stage [N_BUF];
  logic [N_BUF-1:0] chain_busy;

  // Bank 0 issues while RUN has elements left.
  assign b0_en = (state_q == ST_RUN) && (k_q < len_q);

  // Stage 0 is the live bank-0 element; it only enters the chain when staggering.
  assign stage[0]      = '{en: b0_en & stag_q, r_addr: rd_acc_q, w_addr: wr_acc_q};
  assign chain_busy[0] = 1'b0;

  for (genvar i = 1; i < N_BUF; i++) begin : g_chain
    seq_delay_line #(.WIDTH($bits(elem_t)), .DEPTH(1)) u_stage (
      .clk    (clk),
      .rst_n  (rst_n),
      .hold_i (bus.stall),
      .din_i  (stage[i-1]),
      .dout_o (stage[i])
    );
    assign chain_busy[i] = stage[i].en;
  end

  logic [N_BUF-1:0]        r_en_v, w_en_v;
  logic [N_BUF*ADDR_W-1:0] r_addr_v, w_addr_v;

  for (genvar i = 0; i < N_BUF; i++) begin : g_bank
    elem_t           bank_elem;
    logic [ADDR_W:0] wr_out;

    assign bank_elem = ((i == 0) || !stag_q)
                     ? '{en: b0_en, r_addr: rd_acc_q, w_addr: wr_acc_q}
                     : stage[i];

    seq_delay_line #(.WIDTH(ADDR_W+1), .DEPTH(WR_LAT)) u_wr_dly (
      .clk    (clk),
      .rst_n  (rst_n),
      .hold_i (bus.stall),
      .din_i  ({bank_elem.en, bank_elem.w_addr}),
      .dout_o (wr_out)
    );

    // Masked banks keep their (deterministic) addresses but never enable.
    assign r_en_v[i]                     = bank_elem.en & mask_q[i] & ~bus.stall;
    assign r_addr_v[i*ADDR_W +: ADDR_W]  = bank_elem.r_addr;
    assign w_en_v[i]                     = wr_out[ADDR_W] & mask_q[i] & ~bus.stall;
    assign w_addr_v[i*ADDR_W +: ADDR_W]  = wr_out[ADDR_W-1:0];
  end

  assign bus.m1_r_en   = r_en_v;
  assign bus.m1_w_en   = w_en_v;
  assign bus.m1_r_addr = r_addr_v;
  assign bus.m1_w_addr = w_addr_v;
  assign bus.busy      = (state_q != ST_IDLE);
  assign bus.mode      = (state_q != ST_IDLE);
  assign bus.done      = (state_q == ST_DONE);
  assign state_o       = state_q;

  // Next-state and datapath update; a stall freezes everything.
  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    len_d    = len_q;
    stride_d = stride_q;
    rd_acc_d = rd_acc_q;
    wr_acc_d = wr_acc_q;
    mask_d   = mask_q;
    stag_d   = stag_q;
    drain_d  = drain_q;
`ifdef BUF_SEQ_PINGPONG_EN
    pp_d     = pp_q;
`endif
    if (!bus.stall) begin
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            len_d    = bus.len;
            stride_d = bus.stride;
            mask_d   = bus.bank_mask;
            stag_d   = bus.stagger_en;
            rd_acc_d = bus.rd_base ^ msb_flip;
            wr_acc_d = bus.wr_base ^ msb_flip;
            k_d      = '0;
            // An empty pass has nothing to stream and finishes immediately.
            state_d  = (bus.len == '0) ? ST_DONE : ST_RUN;
          end
        end
        ST_RUN: begin
          if (b0_en) begin
            k_d      = k_q + 1'b1;
            rd_acc_d = rd_acc_q + stride_q;
            wr_acc_d = wr_acc_q + stride_q;
          end else if (chain_busy == '0) begin
            // Last read was the previous cycle, so WR_LAT-1 write cycles remain.
            if (WR_LAT == 1) begin
              state_d = ST_DONE;
            end else begin
              state_d = ST_DRAIN;
              drain_d = DW'(WR_LAT - 2);
            end
          end
        end
        ST_DRAIN: begin
          if (drain_q == '0) state_d = ST_DONE;
          else               drain_d = drain_q - 1'b1;
        end
        ST_DONE: begin
          state_d = ST_IDLE;
`ifdef BUF_SEQ_PINGPONG_EN
          pp_d    = ~pp_q;
`endif
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State and configuration registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      k_q      <= '0;
      len_q    <= '0;
      stride_q <= '0;
      rd_acc_q <= '0;
      wr_acc_q <= '0;
      mask_q   <= '0;
      stag_q   <= 1'b0;
      drain_q  <= '0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      len_q    <= len_d;
      stride_q <= stride_d;
      rd_acc_q <= rd_acc_d;
      wr_acc_q <= wr_acc_d;
      mask_q   <= mask_d;
      stag_q   <= stag_d;
      drain_q  <= drain_d;
    end
  end

endmodule

// File: tb/tb_buffer_stream_sequencer.sv
// Directed bench for buffer_stream_sequencer (N_BUF=8, ADDR_W=10, WR_LAT=3).
// Expected enables/addresses come from a closed-form timing model:
// bank i reads element k at un-stalled cycle 1+k(+i if staggered) after start.
module tb_buffer_stream_sequencer;
  import buffer_pkg::*;

  localparam int unsigned NB = 8;
  localparam int unsigned AW = 10;
  localparam int unsigned WL = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  seq_state_t state;
  int         errors = 0;
  int         checks = 0;
  logic       pp_m = 1'b0;

  buffer_stream_sequencer_if #(.N_BUF(NB), .ADDR_W(AW)) bus ();

  buffer_stream_sequencer #(.N_BUF(NB), .ADDR_W(AW), .WR_LAT(WL)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .bus     (bus),
    .state_o (state)
  );

  // Clock.
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_r_en"},   80'(bus.m1_r_en),   80'(0));
    chk({tag, "_w_en"},   80'(bus.m1_w_en),   80'(0));
    chk({tag, "_r_addr"}, 80'(bus.m1_r_addr), 80'(0));
    chk({tag, "_w_addr"}, 80'(bus.m1_w_addr), 80'(0));
    chk({tag, "_busy"},   80'(bus.busy),      80'(0));
    chk({tag, "_mode"},   80'(bus.mode),      80'(0));
    chk({tag, "_done"},   80'(bus.done),      80'(0));
    chk({tag, "_state"},  80'(state),         80'(ST_IDLE));
  endtask

  // Driver + per-cycle checker for one pass. Starts in an idle cycle T.
  task automatic run_pass(input string tag, input logic [9:0] rb, input logic [9:0] wb,
                          input logic [9:0] st, input logic [10:0] ln, input logic [7:0] mk,
                          input logic sg, input int stall_at, input int stall_n,
                          input int again_at, input int abort_at);
    int          t, total, d, ro, wo;
    logic        stl, exp_done;
    logic [7:0]  er, ew;
    logic [79:0] ea_r, ea_w, mr, mw;
    logic [9:0]  frb, fwb;
`ifdef BUF_SEQ_PINGPONG_EN
    frb = rb ^ (pp_m ? 10'h200 : 10'h000);
    fwb = wb ^ (pp_m ? 10'h200 : 10'h000);
`else
    frb = rb;
    fwb = wb;
`endif
    bus.start = 1'b1; bus.rd_base = rb; bus.wr_base = wb; bus.stride = st;
    bus.len = ln; bus.bank_mask = mk; bus.stagger_en = sg; bus.stall = 1'b0;
    @(negedge clk);
    chk({tag, "_idle_busy"}, 80'(bus.busy), 80'(0));
    @(posedge clk); #1;
    // Change every config input; the pass must keep using the latched values.
    bus.start = 1'b0; bus.rd_base = ~rb; bus.wr_base = ~wb; bus.stride = st + 10'd1;
    bus.len = ln + 11'd1; bus.bank_mask = ~mk; bus.stagger_en = ~sg;
    total = (ln == 0) ? 1 : int'(ln) + (sg ? NB - 1 : 0) + WL + 1;
    t = 1;
    for (int c = 1; c <= total + stall_n; c++) begin
      bus.start = (c == again_at);
      stl = (c >= stall_at) && (c < stall_at + stall_n);
      bus.stall = stl;
      if (c == abort_at) begin
        bus.start = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        pp_m = 1'b0;
        @(negedge clk);
        chk_zero({tag, "_abort"});
        @(posedge clk); #1;
        return;
      end
      er = '0; ew = '0; ea_r = '0; ea_w = '0; mr = '0; mw = '0;
      for (int i = 0; i < NB; i++) begin
        d  = sg ? i : 0;
        ro = t - 1 - d;
        wo = t - 1 - int'(WL) - d;
        if (!stl && mk[i] && ro >= 0 && ro < int'(ln)) begin
          er[i] = 1'b1;
          ea_r[i*AW +: AW] = frb + 10'(ro) * st;
          mr[i*AW +: AW]   = '1;
        end
        if (!stl && mk[i] && wo >= 0 && wo < int'(ln)) begin
          ew[i] = 1'b1;
          ea_w[i*AW +: AW] = fwb + 10'(wo) * st;
          mw[i*AW +: AW]   = '1;
        end
      end
      exp_done = !stl && (t == total);
      @(negedge clk);
      chk({tag, "_r_en"},   80'(bus.m1_r_en), 80'(er));
      chk({tag, "_w_en"},   80'(bus.m1_w_en), 80'(ew));
      chk({tag, "_r_addr"}, bus.m1_r_addr & mr, ea_r);
      chk({tag, "_w_addr"}, bus.m1_w_addr & mw, ea_w);
      chk({tag, "_busy"},   80'(bus.busy), 80'(1));
      chk({tag, "_mode"},   80'(bus.mode), 80'(1));
      chk({tag, "_done"},   80'(bus.done), 80'(exp_done));
      @(posedge clk); #1;
      if (!stl) t++;
    end
    bus.start = 1'b0;
    bus.stall = 1'b0;
    pp_m = ~pp_m;
  endtask

  initial begin
    bus.start = 1'b0; bus.rd_base = '0; bus.wr_base = '0; bus.stride = '0;
    bus.len = '0; bus.bank_mask = '0; bus.stagger_en = 1'b0; bus.stall = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk_zero("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;

    run_pass("basic",   10'h010, 10'h080, 10'd1, 11'd4, 8'hFF, 1'b0, 0, 0, 0, 0);
    run_pass("stagger", 10'h010, 10'h080, 10'd1, 11'd4, 8'hFF, 1'b1, 0, 0, 0, 0);
    run_pass("wrap",    10'h3FE, 10'h100, 10'd1, 11'd4, 8'hFF, 1'b0, 0, 0, 0, 0);
    run_pass("stride3", 10'h000, 10'h040, 10'd3, 11'd4, 8'hFF, 1'b0, 0, 0, 0, 0);
    run_pass("stall",   10'h020, 10'h090, 10'd2, 11'd6, 8'h05, 1'b1, 4, 2, 0, 0);
    run_pass("busystart", 10'h010, 10'h080, 10'd1, 11'd4, 8'hFF, 1'b0, 0, 0, 2, 0);
    run_pass("len0",    10'h010, 10'h080, 10'd1, 11'd0, 8'hFF, 1'b0, 0, 0, 0, 0);
    run_pass("abort",   10'h010, 10'h080, 10'd1, 11'd4, 8'hFF, 1'b0, 0, 0, 0, 3);
    run_pass("pp1",     10'h000, 10'h200, 10'd1, 11'd4, 8'hFF, 1'b0, 0, 0, 0, 0);
    run_pass("pp2",     10'h000, 10'h200, 10'd1, 11'd4, 8'hFF, 1'b0, 0, 0, 0, 0);

    @(negedge clk);
    chk("final_busy", 80'(bus.busy), 80'(0));
    chk("final_r_en", 80'(bus.m1_r_en), 80'(0));
    chk("final_w_en", 80'(bus.m1_w_en), 80'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/buffer_stream_sequencer.md
# buffer_stream_sequencer

Parametrised mode-1 address and enable generator for the N_BUF-bank activation buffer. It sits between the layer controller and the buffer bank. It streams strided, optionally staggered (systolic-wavefront) read addresses to every bank, and issues the matching write-back addresses after a fixed PE-array latency. It drives the bank's `mode` select high for the whole pass, so the host (mode-0) port is locked out while streaming.

## Interface
- N_BUF, 8, number of buffer banks
- ADDR_W, `ADDR_RAM, per-bank address width
- WR_LAT, 3, cycles from a bank's read issue to its write-back issue (≥1)
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- start  in  1  pass request; sampled only in IDLE
- rd_base, wr_base  in  ADDR_W  first read / write address
- stride  in  ADDR_W  address increment per element
- len  in  ADDR_W+1  elements per bank (0 allowed)
- bank_mask  in  N_BUF  banks taking part
- stagger_en  in  1  bank i delayed i cycles behind bank 0
- stall  in  1  back-pressure from the PE array; freezes the whole sequencer
- mode  out  1  1 while busy (selects mode 1)
- m1_r_en, m1_w_en  out  N_BUF  per-bank enables
- m1_r_addr, m1_w_addr  out  N_BUF*ADDR_W  per-bank addresses; bank i occupies bits [i*ADDR_W +: ADDR_W]
- busy  out  1  pass in progress
- done  out  1  one-cycle pulse at end of pass

## Operation
- **FSM states:** IDLE → RUN → DRAIN → DONE → IDLE.
  - IDLE→RUN on start. Latch all configuration inputs; later input changes are ignored until the next pass.
  - RUN issues bank-0 elements k=0..len-1. Bank-0 address = base + k*stride, mod 2^ADDR_W (natural wrap). It is produced by an accumulator, not a multiplier.
  - RUN→DRAIN once bank 0 has issued len elements and the stagger chain is empty. With stagger_en=1, bank N_BUF-1 must have issued its last element.
  - DRAIN lasts until the final write enable has been issued. DRAIN→DONE, then DONE→IDLE after one cycle.
- **Stagger:** read enable and address for bank i are those of bank i-1, delayed one cycle (register chain). With stagger_en=0, all banks copy bank 0 in the same cycle.
- **Write-back:** w_en/w_addr of bank i = r_en of bank i, delayed WR_LAT cycles, with write address = wr_base + k*stride (wrapping).
- **bank_mask:** a masked-off bank never asserts r_en or w_en. Its address outputs are don't-care but must stay deterministic.
- **len=0:** RUN→DONE directly. No enables are asserted.
- **stall=1:** every counter, chain and delay register holds its value. All r_en and w_en outputs are forced to 0 that cycle. The FSM does not advance. The elements stalled are then issued later, in the same order, with no element lost or duplicated.
- **start while busy:** ignored; there is no queueing.
- **Reset:** rst_n=0 at any point, including mid-pass, aborts the pass.
  - Next cycle: state IDLE, mode/busy/done/all enables 0, all address outputs 0, delay lines cleared, ping-pong select 0.
  - Writes still in flight are discarded.

## Timing
- start high in IDLE at cycle T:
  - busy=mode=1 from T+1 through the DONE cycle inclusive.
  - Bank-0 first r_en at T+1. Bank i first r_en at T+1+i (staggered) or T+1 (unstaggered).
- Each read at cycle C produces the corresponding write at C+WR_LAT, with stall cycles excluded from the count.
- done pulses exactly one cycle after the last w_en, in the same cycle as busy's final high cycle. The next start is accepted the following cycle.
- Un-stalled pass length = len + (stagger_en ? N_BUF-1 : 0) + WR_LAT + 1 cycles from T+1 to done inclusive.

## Configuration
- BUF_SEQ_PINGPONG_EN defined:
  - A 1-bit select toggles on every done and resets to 0.
  - When the select is 1, the address MSB of both latched bases is inverted at pass start. The read and write halves therefore swap each pass.
- Macro undefined: bases are used exactly as given; no select register exists.

## Structure
- Shared package (buffer_pkg) holds:
  - the FSM state enum (seq_state_t);
  - ADDR_W/N_BUF defaults taken from the header macros;
  - a typedef for the per-bank address vector.
- One sub-module, seq_delay_line, is natural: a parametrised WIDTH×DEPTH shift register with hold (stall) and synchronous clear. It is instantiated for the write enable/address path; the stagger chain can use it too.

## Test plan
- **Basic unstaggered pass:** N_BUF=8, WR_LAT=3, rd_base=0x10, wr_base=0x80, stride=1, len=4, mask=0xFF, stagger_en=0, start at T.
  - All banks: r_en at T+1..T+4 with addresses 0x10..0x13.
  - w_en at T+4..T+7 with addresses 0x80..0x83.
  - done at T+8.
- **Staggered pass:** same as above with stagger_en=1.
  - Bank 7 reads at T+8..T+11 and writes at T+11..T+14.
  - done at T+15; bank i leads bank i+1 by exactly one cycle.
- **Wrap and stride:** rd_base=2^ADDR_W-2, stride=1, len=4 → addresses max-1, max, 0x000, 0x001. Separately, stride=3, base=0 → addresses 0, 3, 6, 9.
- **Stall and mask:** stall for 2 cycles in mid-RUN, bank_mask=0x05.
  - Enables drop to 0 during the stall; the sequence resumes with the next address and no duplicate.
  - done is 2 cycles later than the un-stalled pass.
  - Banks 1, 3–7 never enable.
- **Reset, len=0, busy start:**
  - rst_n low at T+3: all outputs 0 next cycle, and a fresh pass runs cleanly.
  - len=0: done at T+1 with no enables.
  - start while busy: no effect.
- **Ping-pong (BUF_SEQ_PINGPONG_EN):** two back-to-back passes with rd_base=0x000, wr_base=0x200, ADDR_W=10.
  - Second pass reads from 0x200 and writes to 0x000.
